// File: rtl/id_ex_pipeline_reg_if.sv
// ID/EX boundary bundle: decode-stage fields and pipeline controls in, EX-stage copies,
// the load-use hold request and the bubble counter out.
interface id_ex_pipeline_reg_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
);
    logic                      stall;
    logic                      flush;
    logic                      id_valid;
    logic [DATA_WIDTH-1:0]     id_pc_plus4;
    logic [DATA_WIDTH-1:0]     id_rs_data;
    logic [DATA_WIDTH-1:0]     id_rt_data;
    logic [DATA_WIDTH-1:0]     id_imm_ext;
    logic [REG_ADDR_WIDTH-1:0] id_rs;
    logic [REG_ADDR_WIDTH-1:0] id_rt;
    logic [REG_ADDR_WIDTH-1:0] id_rd;
    logic                      id_reg_dst;
    logic                      id_alu_src;
    logic [3:0]                id_alu_op;
    logic                      id_mem_read;
    logic                      id_mem_write;
    logic                      id_mem_to_reg;
    logic                      id_reg_write;

    logic                      ex_valid;
    logic [DATA_WIDTH-1:0]     ex_pc_plus4;
    logic [DATA_WIDTH-1:0]     ex_rs_data;
    logic [DATA_WIDTH-1:0]     ex_rt_data;
    logic [DATA_WIDTH-1:0]     ex_imm_ext;
    logic [REG_ADDR_WIDTH-1:0] ex_rs;
    logic [REG_ADDR_WIDTH-1:0] ex_rt;
    logic [REG_ADDR_WIDTH-1:0] ex_write_reg;
    logic                      ex_alu_src;
    logic [3:0]                ex_alu_op;
    logic                      ex_mem_read;
    logic                      ex_mem_write;
    logic                      ex_mem_to_reg;
    logic                      ex_reg_write;
    logic                      load_use_stall;
    logic [CNT_WIDTH-1:0]      bubble_count;

    modport master (
        output stall, flush, id_valid, id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext,
               id_rs, id_rt, id_rd, id_reg_dst, id_alu_src, id_alu_op,
               id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write,
        input  ex_valid, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext,
               ex_rs, ex_rt, ex_write_reg, ex_alu_src, ex_alu_op,
               ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write,
               load_use_stall, bubble_count
    );

    modport slave (
        input  stall, flush, id_valid, id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext,
               id_rs, id_rt, id_rd, id_reg_dst, id_alu_src, id_alu_op,
               id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write,
        output ex_valid, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext,
               ex_rs, ex_rt, ex_write_reg, ex_alu_src, ex_alu_op,
               ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write,
               load_use_stall, bubble_count
    );
endinterface

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// external stall/flush and a saturating count of inserted bubbles.
module id_ex_pipeline_reg #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    id_ex_pipeline_reg_if.slave  bus
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic                      r_ex_valid;
    logic [DATA_WIDTH-1:0]     r_ex_pc_plus4;
    logic [DATA_WIDTH-1:0]     r_ex_rs_data;
    logic [DATA_WIDTH-1:0]     r_ex_rt_data;
    logic [DATA_WIDTH-1:0]     r_ex_imm_ext;
    logic [REG_ADDR_WIDTH-1:0] r_ex_rs;
    logic [REG_ADDR_WIDTH-1:0] r_ex_rt;
    logic [REG_ADDR_WIDTH-1:0] r_ex_write_reg;
    logic                      r_ex_alu_src;
    logic [3:0]                r_ex_alu_op;
    logic                      r_ex_mem_read;
    logic                      r_ex_mem_write;
    logic                      r_ex_mem_to_reg;
    logic                      r_ex_reg_write;
    logic [CNT_WIDTH-1:0]      r_bubble_count;

    logic [REG_ADDR_WIDTH-1:0] w_dest;
    logic                      w_src_match;
    logic                      w_load_use;
    logic                      w_bubble;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
        if (value == CNT_MAX) begin
            return value;
        end else begin
            return value + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    endfunction

    // Hazard detection; register 0 is hard-wired so a load into it never blocks a consumer.
    always_comb begin
        w_dest      = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
        w_src_match = (r_ex_write_reg == bus.id_rs) || (r_ex_write_reg == bus.id_rt);
        if (reset) begin
            w_load_use = 1'b0;
        end else begin
            w_load_use = r_ex_valid & r_ex_mem_read & (r_ex_write_reg != {REG_ADDR_WIDTH{1'b0}})
                       & bus.id_valid & w_src_match;
        end
        // Flush outranks stall; a load-use bubble only happens when the stage is free to advance.
        w_bubble = bus.flush | (~bus.stall & w_load_use);
    end

    // Pipeline fields: reset and bubble both clear everything so a bubble can never forward.
    always_ff @(posedge clk) begin
        if (reset || w_bubble) begin
            r_ex_valid      <= 1'b0;
            r_ex_pc_plus4   <= {DATA_WIDTH{1'b0}};
            r_ex_rs_data    <= {DATA_WIDTH{1'b0}};
            r_ex_rt_data    <= {DATA_WIDTH{1'b0}};
            r_ex_imm_ext    <= {DATA_WIDTH{1'b0}};
            r_ex_rs         <= {REG_ADDR_WIDTH{1'b0}};
            r_ex_rt         <= {REG_ADDR_WIDTH{1'b0}};
            r_ex_write_reg  <= {REG_ADDR_WIDTH{1'b0}};
            r_ex_alu_src    <= 1'b0;
            r_ex_alu_op     <= 4'd0;
            r_ex_mem_read   <= 1'b0;
            r_ex_mem_write  <= 1'b0;
            r_ex_mem_to_reg <= 1'b0;
            r_ex_reg_write  <= 1'b0;
        end else if (!bus.stall) begin
            r_ex_valid      <= bus.id_valid;
            r_ex_pc_plus4   <= bus.id_pc_plus4;
            r_ex_rs_data    <= bus.id_rs_data;
            r_ex_rt_data    <= bus.id_rt_data;
            r_ex_imm_ext    <= bus.id_imm_ext;
            r_ex_rs         <= bus.id_rs;
            r_ex_rt         <= bus.id_rt;
            r_ex_write_reg  <= w_dest;
            r_ex_alu_src    <= bus.id_alu_src;
            r_ex_alu_op     <= bus.id_alu_op;
            r_ex_mem_read   <= bus.id_mem_read;
            r_ex_mem_write  <= bus.id_mem_write;
            r_ex_mem_to_reg <= bus.id_mem_to_reg;
            r_ex_reg_write  <= bus.id_reg_write;
        end
    end

    // Bubble counter: one increment per bubble edge, even when flush and load-use coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bubble_count <= {CNT_WIDTH{1'b0}};
        end else if (w_bubble) begin
            r_bubble_count <= sat_inc(r_bubble_count);
        end
    end

    assign bus.ex_valid       = r_ex_valid;
    assign bus.ex_pc_plus4    = r_ex_pc_plus4;
    assign bus.ex_rs_data     = r_ex_rs_data;
    assign bus.ex_rt_data     = r_ex_rt_data;
    assign bus.ex_imm_ext     = r_ex_imm_ext;
    assign bus.ex_rs          = r_ex_rs;
    assign bus.ex_rt          = r_ex_rt;
    assign bus.ex_write_reg   = r_ex_write_reg;
    assign bus.ex_alu_src     = r_ex_alu_src;
    assign bus.ex_alu_op      = r_ex_alu_op;
    assign bus.ex_mem_read    = r_ex_mem_read;
    assign bus.ex_mem_write   = r_ex_mem_write;
    assign bus.ex_mem_to_reg  = r_ex_mem_to_reg;
    assign bus.ex_reg_write   = r_ex_reg_write;
    assign bus.load_use_stall = w_load_use;
    assign bus.bubble_count   = r_bubble_count;
endmodule
